// File: rtl/hazard_ctrl.sv
// Hazard/freeze controller for the 5-stage RV64 pipeline: load-use stall, branch flush, dmem wait.
// Define HAZARD_PERF_CNT_EN to build the stall/flush performance counters.
module hazard_ctrl #(
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic              ex_mem_read,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_branch_taken,
  input  logic              mem_access,
  input  logic              dmem_ready,
  output logic              pc_write_en,
  output logic              if_id_write_en,
  output logic              id_ex_write_en,
  output logic              ex_mem_write_en,
  output logic              if_id_flush,
  output logic              id_ex_flush,
  output logic              mem_wb_bubble,
  output logic [1:0]        state_o,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LU_STALL = 2'd1,
    BR_FLUSH = 2'd2,
    MEM_WAIT = 2'd3
  } state_e;

  state_e state_q, state_d;
  logic   lu, mw, bt, lu_eff;

  always_comb begin
    lu     = ex_mem_read && (ex_rd != '0) &&
             ((id_use_rs1 && (ex_rd == id_rs1)) || (id_use_rs2 && (ex_rd == id_rs2)));
    mw     = mem_access && !dmem_ready;
    // Qualifying on the recorded action stops a flushed bubble or the
    // already-stalled consumer from triggering the same hazard again.
    bt     = ex_branch_taken && (state_q != BR_FLUSH);
    lu_eff = lu && (state_q != LU_STALL);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= RUN;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = RUN;
    if (mw)          state_d = MEM_WAIT;
    else if (bt)     state_d = BR_FLUSH;
    else if (lu_eff) state_d = LU_STALL;
  end

  always_comb begin
    pc_write_en     = 1'b1;
    if_id_write_en  = 1'b1;
    id_ex_write_en  = 1'b1;
    ex_mem_write_en = 1'b1;
    if_id_flush     = 1'b0;
    id_ex_flush     = 1'b0;
    mem_wb_bubble   = 1'b0;
    if (reset) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
    end else if (mw) begin
      pc_write_en     = 1'b0;
      if_id_write_en  = 1'b0;
      id_ex_write_en  = 1'b0;
      ex_mem_write_en = 1'b0;
      mem_wb_bubble   = 1'b1;
    end else if (bt) begin
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (lu_eff) begin
      pc_write_en    = 1'b0;
      if_id_write_en = 1'b0;
      id_ex_flush    = 1'b1;
    end
  end

  assign state_o = state_q;

`ifdef HAZARD_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write_en && (stall_cnt_q != '1)) stall_cnt_d = stall_cnt_q + 1'b1;
    if (bt && (flush_cnt_q != '1))           flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
`else
  assign stall_cnt = '0;
  assign flush_cnt = '0;
`endif

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard and freeze controller for the 5-stage 64-bit RISC-V core. It reads decode-stage register addresses, the ID/EX outputs (mem_read, rd), and the EX-stage branch outcome. From these it drives the flush inputs of IF/ID and ID/EX and the write enables of the PC and the stage registers. A registered state machine records the last hazard action, which suppresses spurious re-detection and sequences multi-cycle data-memory waits.

## Interface
Parameters:
- REG_AW, 5, register address width
- CNT_W, 32, performance counter width

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous, active-high
- id_rs1  in  REG_AW  rs1 of the instruction in ID
- id_rs2  in  REG_AW  rs2 of the instruction in ID
- id_use_rs1  in  1  ID instruction reads rs1
- id_use_rs2  in  1  ID instruction reads rs2
- ex_mem_read  in  1  ID/EX mem_read output
- ex_rd  in  REG_AW  ID/EX rd output
- ex_branch_taken  in  1  branch in EX resolved taken
- mem_access  in  1  EX/MEM holds a load or store
- dmem_ready  in  1  data memory completes access this cycle
- pc_write_en  out  1  PC update enable
- if_id_write_en  out  1  IF/ID load enable
- id_ex_write_en  out  1  ID/EX load enable
- ex_mem_write_en  out  1  EX/MEM load enable
- if_id_flush  out  1  IF/ID clear to bubble
- id_ex_flush  out  1  ID/EX clear to bubble
- mem_wb_bubble  out  1  MEM/WB loads a bubble
- state_o  out  2  current state: RUN=0, LU_STALL=1, BR_FLUSH=2, MEM_WAIT=3
- stall_cnt  out  CNT_W  stall cycle count
- flush_cnt  out  CNT_W  branch flush count

## Operation
- Define lu = ex_mem_read & (ex_rd != 0) & ((id_use_rs1 & ex_rd == id_rs1) | (id_use_rs2 & ex_rd == id_rs2)).
- Define mw = mem_access & ~dmem_ready.
- Define bt = ex_branch_taken & (state != BR_FLUSH). A taken signal in the cycle after a flush comes from a bubble and is ignored.
- Define lu_eff = lu & (state != LU_STALL). This guarantees exactly one stall cycle per load-use pair.
- The outputs are combinational from state and inputs. Only one action applies per cycle, in priority order mw > bt > lu_eff > none:
  - mw: all four write enables 0, mem_wb_bubble=1, no flush. Next state MEM_WAIT.
  - bt: all enables 1, if_id_flush=1, id_ex_flush=1. Next state BR_FLUSH.
  - lu_eff: pc_write_en=0, if_id_write_en=0, id_ex_flush=1, id_ex_write_en=1, ex_mem_write_en=1. Next state LU_STALL.
  - none: all enables 1, flushes 0, bubble 0. Next state RUN.
- MEM_WAIT freezes the whole pipeline. Any branch or load-use condition present during the freeze is held and re-evaluated on the first cycle in which dmem_ready=1.
- A flush takes precedence over a write enable at the target register.

## Timing
- Hazard response is zero-latency: outputs are valid in the same cycle as the inputs. The state register updates at posedge clk.
- Load-use: exactly 1 stall cycle. The consumer reaches EX two cycles after the load does.
- Branch: the 2 younger instructions are squashed in the single cycle in which bt is asserted.
- Memory wait: the freeze lasts N cycles for N cycles of dmem_ready=0, with no extra cycle on exit.
- While reset is asserted:
  - state=RUN.
  - All write enables are 0 and all flushes and mem_wb_bubble are 0.
  - Counters are 0.
- A reset asserted mid-MEM_WAIT or mid-LU_STALL returns the block to RUN immediately and asynchronously.
- Counters update at posedge clk and saturate at all-ones without wrapping:
  - stall_cnt increments on every cycle with pc_write_en=0.
  - flush_cnt increments on every bt cycle.

## Configuration
- HAZARD_PERF_CNT_EN defined: stall_cnt and flush_cnt are implemented as described.
- HAZARD_PERF_CNT_EN undefined: no counter flops exist, and stall_cnt and flush_cnt are constant 0. Ports are unchanged.

## Test plan
- Load x5 followed by `add x6,x5,x1`; ex_mem_read=1, ex_rd=5, id_rs1=5, id_use_rs1=1 -> exactly one cycle with pc_write_en=0 and id_ex_flush=1, state 0→1→0, stall_cnt=1.
- Same sequence with ex_rd=0 or id_use_rs1=0 -> no stall, state stays RUN.
- ex_branch_taken=1 for two consecutive cycles -> first cycle asserts both flushes with state→BR_FLUSH; second cycle is ignored; flush_cnt=1.
- mem_access=1 with dmem_ready=0 for 3 cycles and lu also true -> 3 cycles with all enables 0 and mem_wb_bubble=1, then 1 load-use stall cycle; stall_cnt=4.
- mw and bt in the same cycle -> freeze only; the flush is issued on the cycle dmem_ready=1.
- Reset asserted mid-MEM_WAIT -> state_o=0 and counters 0 asynchronously, enables 0 until reset is released.
